// File: rtl/store.sv
// Serial-byte loader: writes DEPTH received bytes to consecutive memory addresses.
// Define STORE_CHECKSUM_EN to enable the running mod-256 byte checksum output.
module store #(
    parameter int DEPTH = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [13:0] write_select,
    output logic [7:0]  write_data,
    output logic        write_en,
    output logic        busy,
    output logic        load_done,
    output logic [7:0]  checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [13:0] r_addr;
    logic [13:0] r_write_select;
    logic [7:0]  r_write_data;
    logic        r_write_en;
    logic        r_busy;
    logic        r_load_done;
    logic        w_accept;
    logic        w_last;
    logic        w_restart;

    assign w_accept  = (r_state == LOAD) && rx_valid;
    assign w_last    = (r_addr == LAST_ADDR);
    assign w_restart = (r_state != LOAD) && start;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next_state = LOAD;
            LOAD:       if (w_accept && w_last) w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state == LOAD);
            r_load_done <= (w_next_state == DONE);
        end
    end

    // The address saturates on the last byte; the next start clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr         <= '0;
            r_write_select <= '0;
            r_write_data   <= '0;
            r_write_en     <= 1'b0;
        end else begin
            r_write_en <= w_accept;
            if (w_accept) begin
                r_write_select <= r_addr;
                r_write_data   <= rx_data;
                if (!w_last) r_addr <= r_addr + 14'd1;
            end else if (w_restart) begin
                r_addr <= '0;
            end
        end
    end

`ifdef STORE_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (w_restart) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + rx_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign write_select = r_write_select;
    assign write_data   = r_write_data;
    assign write_en     = r_write_en;
    assign busy         = r_busy;
    assign load_done    = r_load_done;

endmodule

// File: tb/tb_store.sv
// Self-checking bench for store: byte-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_store;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [13:0] write_select;
    logic [7:0]  write_data;
    logic        write_en;
    logic        busy;
    logic        load_done;
    logic [7:0]  checksum;

    int checks = 0;
    int errors = 0;

    // reference model: loading flag plus count of bytes written since start
    bit       mActive = 1'b0;
    bit       mFinished = 1'b0;
    int       mCount = 0;
    int       mSel = 0;
    int       mData = 0;
    bit       mEn = 1'b0;
    int       mSum = 0;

    int       obsAddr[$];
    int       obsData[$];

    store #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .write_select(write_select),
        .write_data(write_data),
        .write_en(write_en),
        .busy(busy),
        .load_done(load_done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int expChecksum(int s);
`ifdef STORE_CHECKSUM_EN
        return s;
`else
        return 0;
`endif
    endfunction

    // Model update on each rising edge, DUT comparison 1 time unit later.
    always begin
        bit sStart;
        bit sValid;
        bit sRst;
        int sData;
        @(posedge clk);
        sRst = rst;
        sStart = start;
        sValid = rx_valid;
        sData = int'(rx_data);
        if (!sRst) begin
            mActive = 0; mFinished = 0; mCount = 0;
            mSel = 0; mData = 0; mEn = 0; mSum = 0;
        end else begin
            mEn = 0;
            if (!mActive) begin
                if (sStart) begin
                    mActive = 1; mFinished = 0; mCount = 0; mSum = 0;
                end
            end else if (sValid) begin
                mEn = 1;
                mSel = mCount;
                mData = sData;
                mSum = (mSum + sData) % 256;
                mCount++;
                if (mCount == DEPTH) begin
                    mActive = 0;
                    mFinished = 1;
                end
            end
        end
        #1;
        checkOutput("write_en", int'(write_en), int'(mEn));
        checkOutput("write_select", int'(write_select), mSel);
        checkOutput("write_data", int'(write_data), mData);
        checkOutput("busy", int'(busy), int'(mActive));
        checkOutput("load_done", int'(load_done), int'(mFinished));
        checkOutput("checksum", int'(checksum), expChecksum(mSum));
        if (write_en) begin
            obsAddr.push_back(int'(write_select));
            obsData.push_back(int'(write_data));
        end
    end

    task automatic applyStimulus(input bit s, input bit v, input logic [7:0] d);
        start = s;
        rx_valid = v;
        rx_data = d;
        @(negedge clk);
        start = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_write_en", int'(write_en), 0);
        checkOutput("rst_write_select", int'(write_select), 0);
        checkOutput("rst_write_data", int'(write_data), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_load_done", int'(load_done), 0);
        checkOutput("rst_checksum", int'(checksum), 0);
        rst = 1'b1;
        obsAddr.delete();
        obsData.delete();
    endtask

    task automatic checkWrites(string name, int n, int baseData, int stepData);
        checkOutput({name, "_count"}, obsAddr.size(), n);
        for (int i = 0; i < n && i < obsAddr.size(); i++) begin
            checkOutput({name, "_addr"}, obsAddr[i], i);
            checkOutput({name, "_data"}, obsData[i], baseData + i * stepData);
        end
    endtask

    initial begin
        @(negedge clk);
        doReset();

        // back-to-back load of 0x11..0x44
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i * 'h11));
        checkOutput("b2b_load_done", int'(load_done), 1);
        checkOutput("b2b_busy", int'(busy), 0);
        checkOutput("b2b_checksum", int'(checksum), expChecksum('hAA));
        checkWrites("b2b", 4, 'h11, 'h11);
        idleCycles(2);
        checkOutput("b2b_hold_checksum", int'(checksum), expChecksum('hAA));

        // spaced bytes then a stray byte in DONE
        obsAddr.delete(); obsData.delete();
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
            idleCycles(2);
        end
        applyStimulus(1'b0, 1'b1, 8'h55);
        idleCycles(2);
        checkWrites("spaced", 4, 'h10, 1);
        checkOutput("spaced_done", int'(load_done), 1);

        // reset in mid-load, then a clean load of 0xA0..0xA3
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h02);
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(8'hA0 + i));
        checkWrites("after_rst", 4, 'hA0, 1);

        // start and rx_valid together from IDLE drop the byte
        doReset();
        applyStimulus(1'b1, 1'b1, 8'h77);
        applyStimulus(1'b0, 1'b1, 8'h88);
        checkOutput("same_cycle_count", obsAddr.size(), 1);
        if (obsAddr.size() > 0) begin
            checkOutput("same_cycle_addr", obsAddr[0], 0);
            checkOutput("same_cycle_data", obsData[0], 'h88);
        end

        // start pulsed mid-load is ignored
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hC0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 1; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i));
        checkWrites("no_restart", 4, 'hC0, 1);
        checkOutput("no_restart_done", int'(load_done), 1);

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                idleCycles(int'($urandom_range(1, 2)));
                rst = 1'b1;
            end else begin
                applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
                              8'($urandom_range(0, 255)));
            end
        end

        idleCycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store.md
STORE -- requirements
Module: store

Interface
REQ-001 Parameter DEPTH, default 16384, number of bytes written per load (1..16384).
REQ-002 Port clk  input  1  single clock; all state on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-004 Port start  input  1  level sampled each cycle; begins a load from IDLE or DONE.
REQ-005 Port rx_data  input  8  byte delivered by the serial receiver.
REQ-006 Port rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
REQ-007 Port write_select  output  14  memory write address.
REQ-008 Port write_data  output  8  memory write byte.
REQ-009 Port write_en  output  1  memory write strobe, one cycle per byte.
REQ-010 Port busy  output  1  high while in LOAD.
REQ-011 Port load_done  output  1  high while in DONE.
REQ-012 Port checksum  output  8  running byte sum (see Configuration).

Function
REQ-013 FSM states IDLE, LOAD, DONE; all outputs registered.
REQ-014 IDLE or DONE, start=1 -> LOAD next cycle; address counter cleared to 0, checksum cleared to 0.
REQ-015 LOAD, rx_valid=1 -> next cycle write_en=1, write_data=rx_data, write_select=current address; address then increments by 1.
REQ-016 Latency rx_valid -> write_en exactly 1 cycle; back-to-back rx_valid every cycle accepted without loss.
REQ-017 write_en=0 on every cycle not following an accepted byte; write_select/write_data hold last written values.
REQ-018 Byte at address DEPTH-1 accepted -> DONE on the same edge as its write_en rises; address never exceeds DEPTH-1 and never wraps.
REQ-019 start in LOAD ignored; no restart until DONE.
REQ-020 rx_valid in IDLE or DONE dropped: no write, no address or checksum change.
REQ-021 start and rx_valid in the same cycle from IDLE/DONE: rx_valid dropped, transition to LOAD per REQ-014.
REQ-022 DONE holds load_done=1 until start=1; busy=1 exactly in LOAD.
REQ-023 DEPTH=1: first accepted byte goes to address 0, then DONE.

Reset
REQ-024 rst=0 forces IDLE immediately, any cycle including mid-LOAD.
REQ-025 Reset values: write_select=0, write_data=0, write_en=0, busy=0, load_done=0, checksum=0, address=0.
REQ-026 Interrupted load is abandoned; after rst=1 a new start restarts at address 0.

Configuration
REQ-027 Macro STORE_CHECKSUM_EN defined: checksum = sum mod 256 of all bytes written since last start, updated on the same edge as write_en rises, held in DONE.
REQ-028 STORE_CHECKSUM_EN undefined: checksum tied to 0, no adder logic; all other behaviour identical.

Verification
REQ-029 DEPTH=4, start, bytes 0x11,0x22,0x33,0x44 back-to-back -> writes at 0..3 with matching data, one cycle after each rx_valid; load_done=1, busy=0 after 4th.
REQ-030 With STORE_CHECKSUM_EN, same stimulus -> checksum=0xAA in DONE; without macro -> checksum=0x00.
REQ-031 DEPTH=4, bytes spaced 3 cycles apart, extra rx_valid 0x55 in DONE -> exactly 4 write_en pulses, no write of 0x55.
REQ-032 DEPTH=4, rst=0 after 2 bytes, release, start, 4 bytes 0xA0..0xA3 -> all outputs 0 during reset; writes restart at address 0.
REQ-033 rx_valid 0x77 with start in the same IDLE cycle -> no write; next byte 0x88 written at address 0.
REQ-034 start pulsed during LOAD after byte 1 -> address continues at 1, no restart; DONE after DEPTH total bytes.
